// File: rtl/leb128_reader_if.sv
// ----------------------------------------------------------------------------
// leb128_reader_if
//   Bundles the request, response and ROM-window signals of leb128_reader.
//
//   Handshake rule (req_* and rsp_*): a transfer happens on a rising clock
//   edge where valid and ready are both 1. Once valid is raised, the producer
//   holds valid and its payload stable until that edge. Ready may change
//   freely and never depends combinationally on valid.
//
//   Signals
//     req_valid/req_ready   request handshake
//     req_addr              ROM byte address of the first LEB128 byte
//     req_signed            1 = sLEB128, 0 = uLEB128
//     req_is64              1 = i64 form (up to 10 bytes), 0 = i32 form (5)
//     rsp_valid/rsp_ready   response handshake
//     rsp_value             decoded 64-bit value
//     rsp_len               bytes consumed
//     rsp_trap              0 none, 1 ROM error, 2 overlong, 3 bad final byte
//     mem_addr              ROM window address
//     mem_extra             window size select (all ones)
//     mem_data              ROM window, byte k at [8k+7:8k], one cycle late
//     mem_error             ROM bound error, aligned with mem_data
//
//   Modports
//     slave   : the reader itself
//     master  : the requester / ROM side
// ----------------------------------------------------------------------------
interface leb128_reader_if #(
  parameter int MEM_DEPTH = 4,
  parameter int MEM_EXTRA = 4
);
  logic                          req_valid;
  logic                          req_ready;
  logic [MEM_DEPTH:0]            req_addr;
  logic                          req_signed;
  logic                          req_is64;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [63:0]                   rsp_value;
  logic [3:0]                    rsp_len;
  logic [3:0]                    rsp_trap;
  logic [MEM_DEPTH:0]            mem_addr;
  logic [MEM_EXTRA-1:0]          mem_extra;
  logic [(2**MEM_EXTRA)*8-1:0]   mem_data;
  logic                          mem_error;

  modport slave (
    input  req_valid, req_addr, req_signed, req_is64,
    output req_ready,
    output rsp_valid, rsp_value, rsp_len, rsp_trap,
    input  rsp_ready,
    output mem_addr, mem_extra,
    input  mem_data, mem_error
  );

  modport master (
    output req_valid, req_addr, req_signed, req_is64,
    input  req_ready,
    input  rsp_valid, rsp_value, rsp_len, rsp_trap,
    output rsp_ready,
    input  mem_addr, mem_extra,
    output mem_data, mem_error
  );
endinterface

// File: rtl/leb128_reader.sv
// ----------------------------------------------------------------------------
// leb128_reader
//   Immediate-operand fetch stage. On a request it reads one ROM window and
//   decodes a single unsigned or signed LEB128 immediate in i32 or i64 form,
//   returning the value, the number of bytes consumed and a trap code.
//
//   Parameters
//     MEM_DEPTH  ROM address width; addresses are MEM_DEPTH+1 bits
//     MEM_EXTRA  log2 of window bytes, must be >= 4 (16-byte window)
//
//   Ports
//     clk          clock, all state on the rising edge
//     reset        synchronous, active-high
//     bus          leb128_reader_if.slave (request, response, ROM window)
//     dbg_state_o  current FSM state (IDLE=0 FETCH=1 CAPTURE=2 DECODE=3
//                  DONE=4)
//
//   Build option
//     LEB128_STRICT_EN  when defined, the final byte of a maximum-length
//                       encoding must not carry bits beyond the target width;
//                       a violation reports trap 3. When undefined, excess
//                       bits are truncated silently.
// ----------------------------------------------------------------------------
module leb128_reader #(
  parameter int MEM_DEPTH = 4,
  parameter int MEM_EXTRA = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  leb128_reader_if.slave        bus,
  output logic [2:0]            dbg_state_o
);

  localparam int AW       = MEM_DEPTH + 1;
  localparam int WIN_BITS = (2 ** MEM_EXTRA) * 8;
  localparam int IW       = $clog2(WIN_BITS);

  generate
    if (MEM_EXTRA < 4) begin : g_bad_window
      $error("leb128_reader: MEM_EXTRA must be >= 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_DECODE  = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e                state_q;
  logic [AW-1:0]         addr_q;
  logic                  signed_q;
  logic                  is64_q;
  logic [3:0]            k_q;
  logic [63:0]           acc_q;
  logic [WIN_BITS-1:0]   window_q;
  logic                  cap_wait_q;

  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic [63:0]           rsp_value_q;
  logic [3:0]            rsp_len_q;
  logic [3:0]            rsp_trap_q;
  logic [AW-1:0]         mem_addr_q;

  // Decode-path helpers for the byte at index k_q.
  logic [IW-1:0]         bit_idx_d;
  logic [7:0]            byte_d;
  logic [6:0]            sh_d;
  logic [63:0]           contrib_d;
  logic [63:0]           acc_d;
  logic [3:0]            len_d;
  logic [6:0]            lsh_d;
  logic [63:0]           ext_d;
  logic [63:0]           final_d;
  logic                  last_d;
  logic                  bad_d;

  always_comb begin
    bit_idx_d = IW'({k_q, 3'b000});
    byte_d    = window_q[bit_idx_d +: 8];
    // 7*k without a multiplier: 8k - k
    sh_d      = {k_q, 3'b000} - {3'b000, k_q};
    // Payload bits that land above bit 63 fall off the shift.
    contrib_d = {57'd0, byte_d[6:0]} << sh_d;
    acc_d     = acc_q | contrib_d;
    len_d     = k_q + 4'd1;
    lsh_d     = {len_d, 3'b000} - {3'b000, len_d};
    last_d    = is64_q ? (k_q == 4'd9) : (k_q == 4'd4);

    // Sign-extend from bit 7*len-1. For a 10-byte value the payload already
    // fills all 64 bits, so nothing is left to extend.
    ext_d = acc_d;
    if (signed_q && (lsh_d < 7'd64)) begin
      if (acc_d[6'(lsh_d - 7'd1)]) begin
        ext_d = acc_d | (~64'd0 << lsh_d);
      end
    end

    final_d = ext_d;
    if (!is64_q) begin
      final_d = signed_q ? {{32{ext_d[31]}}, ext_d[31:0]} : {32'd0, ext_d[31:0]};
    end

`ifdef LEB128_STRICT_EN
    // Only a maximum-length final byte can carry bits past the target width.
    bad_d = 1'b0;
    if (last_d) begin
      if (is64_q) begin
        bad_d = signed_q ? (byte_d[6:1] != {6{byte_d[0]}}) : (byte_d[6:1] != 6'd0);
      end else begin
        bad_d = signed_q ? (byte_d[6:4] != {3{byte_d[3]}}) : (byte_d[6:4] != 3'd0);
      end
    end
`else
    bad_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      signed_q    <= 1'b0;
      is64_q      <= 1'b0;
      k_q         <= 4'd0;
      acc_q       <= 64'd0;
      window_q    <= '0;
      cap_wait_q  <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_value_q <= 64'd0;
      rsp_len_q   <= 4'd0;
      rsp_trap_q  <= 4'd0;
      mem_addr_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            addr_q      <= bus.req_addr;
            signed_q    <= bus.req_signed;
            is64_q      <= bus.req_is64;
            acc_q       <= 64'd0;
            k_q         <= 4'd0;
            req_ready_q <= 1'b0;
            state_q     <= S_FETCH;
          end
        end

        S_FETCH: begin
          mem_addr_q <= addr_q;
          cap_wait_q <= 1'b1;
          state_q    <= S_CAPTURE;
        end

        S_CAPTURE: begin
          // mem_addr is registered, so the ROM sees it one cycle after FETCH
          // and answers one cycle later; the first CAPTURE cycle just waits.
          if (cap_wait_q) begin
            cap_wait_q <= 1'b0;
          end else begin
            window_q <= bus.mem_data;
            if (bus.mem_error) begin
              rsp_valid_q <= 1'b1;
              rsp_value_q <= 64'd0;
              rsp_len_q   <= 4'd0;
              rsp_trap_q  <= 4'd1;
              state_q     <= S_DONE;
            end else begin
              state_q <= S_DECODE;
            end
          end
        end

        S_DECODE: begin
          acc_q <= acc_d;
          if (!byte_d[7]) begin
            rsp_valid_q <= 1'b1;
            rsp_len_q   <= len_d;
            if (bad_d) begin
              rsp_value_q <= 64'd0;
              rsp_trap_q  <= 4'd3;
            end else begin
              rsp_value_q <= final_d;
              rsp_trap_q  <= 4'd0;
            end
            state_q <= S_DONE;
          end else if (last_d) begin
            rsp_valid_q <= 1'b1;
            rsp_len_q   <= len_d;
            rsp_value_q <= 64'd0;
            rsp_trap_q  <= 4'd2;
            state_q     <= S_DONE;
          end else begin
            k_q <= len_d;
          end
        end

        S_DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_value = rsp_value_q;
  assign bus.rsp_len   = rsp_len_q;
  assign bus.rsp_trap  = rsp_trap_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_extra = '1;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_leb128_reader.sv
module tb_leb128_reader;

  localparam int MEM_DEPTH = 4;
  localparam int MEM_EXTRA = 4;
  localparam int ROM_BYTES = 32;
  localparam int WIN       = 16;

  typedef struct {
    logic [4:0]  addr;
    bit          sgn;
    bit          is64;
    logic [63:0] val;
    logic [3:0]  len;
    logic [3:0]  trap;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [2:0] dbg_state;

  leb128_reader_if #(.MEM_DEPTH(MEM_DEPTH), .MEM_EXTRA(MEM_EXTRA)) bus ();

  leb128_reader #(.MEM_DEPTH(MEM_DEPTH), .MEM_EXTRA(MEM_EXTRA)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- ROM model ----------------
  logic [7:0] rom [ROM_BYTES];

  always @(posedge clk) begin
    logic [WIN*8-1:0] w;
    for (int k = 0; k < WIN; k++) begin
      w[8*k +: 8] = rom[(int'(bus.mem_addr) + k) % ROM_BYTES];
    end
    bus.mem_data  <= w;
    bus.mem_error <= (int'(bus.mem_addr) + WIN > ROM_BYTES);
  end

  // ---------------- scoreboard ----------------
  logic [71:0] exp_q[$];
  int          exp_lat_q[$];
  int          acc_cyc_q[$];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ---------------- monitor ----------------
  bit prev_v = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 72'(bus.rsp_valid), 72'(0));
        end else begin
          if (!prev_v) begin
            if (acc_cyc_q.size() == 0) begin
              fail_now("accept_record");
            end else begin
              check("latency", 72'(cyc - acc_cyc_q.pop_front()), 72'(exp_lat_q.pop_front()));
            end
          end
          check("rsp_fields", {bus.rsp_value, bus.rsp_len, bus.rsp_trap}, exp_q[0]);
          if (bus.rsp_ready) void'(exp_q.pop_front());
        end
      end
      prev_v = bus.rsp_valid;
    end
  end

  // ---------------- driver ----------------
  task automatic send(input vec_t v, input bit expect_rsp);
    int n = 0;
    while (!bus.req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.req_ready) begin
      fail_now("req_ready_wait");
      return;
    end
    bus.req_valid  = 1'b1;
    bus.req_addr   = v.addr;
    bus.req_signed = v.sgn;
    bus.req_is64   = v.is64;
    if (expect_rsp) begin
      exp_q.push_back({v.val, v.len, v.trap});
      exp_lat_q.push_back(v.trap == 4'd1 ? 3 : 3 + int'(v.len));
    end
    @(posedge clk); #1;
    if (expect_rsp) acc_cyc_q.push_back(cyc);
    bus.req_valid = 1'b0;
  endtask

  vec_t vecs[15];
  vec_t v_err;
  vec_t v_rst;

  initial begin
    // ROM contents
    for (int i = 0; i < ROM_BYTES; i++) rom[i] = 8'h00;
    rom[0]  = 8'h05;
    rom[1]  = 8'hE5; rom[2]  = 8'h8E; rom[3]  = 8'h26;
    rom[4]  = 8'hC0; rom[5]  = 8'hBB; rom[6]  = 8'h78;
    rom[7]  = 8'h7F;
    rom[8]  = 8'h80; rom[9]  = 8'h80; rom[10] = 8'h80;
    rom[11] = 8'h80; rom[12] = 8'h80; rom[13] = 8'h00;
    rom[14] = 8'hFF; rom[15] = 8'hFF; rom[16] = 8'hFF;
    rom[17] = 8'hFF; rom[18] = 8'h7F;

    // directed vectors: addr, signed, is64, value, len, trap
    vecs[0]  = '{5'd0,  1'b0, 1'b0, 64'd5,                  4'd1, 4'd0};
    vecs[1]  = '{5'd1,  1'b0, 1'b1, 64'h98765,              4'd3, 4'd0};
    vecs[2]  = '{5'd1,  1'b1, 1'b1, 64'h98765,              4'd3, 4'd0};
    vecs[3]  = '{5'd4,  1'b1, 1'b0, 64'hFFFF_FFFF_FFFE_1DC0, 4'd3, 4'd0};
    vecs[4]  = '{5'd7,  1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 4'd0};
    vecs[5]  = '{5'd7,  1'b0, 1'b1, 64'h7F,                 4'd1, 4'd0};
    vecs[6]  = '{5'd8,  1'b0, 1'b0, 64'd0,                  4'd5, 4'd2};
    vecs[7]  = '{5'd8,  1'b1, 1'b0, 64'd0,                  4'd5, 4'd2};
    vecs[8]  = '{5'd8,  1'b0, 1'b1, 64'd0,                  4'd6, 4'd0};
`ifdef LEB128_STRICT_EN
    vecs[9]  = '{5'd14, 1'b0, 1'b0, 64'd0,                  4'd5, 4'd3};
`else
    vecs[9]  = '{5'd14, 1'b0, 1'b0, 64'hFFFF_FFFF,          4'd5, 4'd0};
`endif
    vecs[10] = '{5'd14, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd5, 4'd0};
    vecs[11] = '{5'd14, 1'b0, 1'b1, 64'h7_FFFF_FFFF,        4'd5, 4'd0};
    vecs[12] = '{5'd16, 1'b0, 1'b0, 64'h1F_FFFF,            4'd3, 4'd0};
    vecs[13] = '{5'd17, 1'b0, 1'b0, 64'd0,                  4'd0, 4'd1};
    vecs[14] = '{5'd0,  1'b1, 1'b1, 64'd5,                  4'd1, 4'd0};
    v_err    = '{5'd20, 1'b0, 1'b0, 64'd0,                  4'd0, 4'd1};
    v_rst    = '{5'd8,  1'b0, 1'b1, 64'd0,                  4'd6, 4'd0};

    // reset
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_signed = 1'b0;
    bus.req_is64   = 1'b0;
    bus.rsp_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 72'(bus.req_ready), 72'(1));
    check("rst_rsp_valid", 72'(bus.rsp_valid), 72'(0));
    check("rst_rsp_value", 72'(bus.rsp_value), 72'(0));
    check("rst_rsp_len",   72'(bus.rsp_len),   72'(0));
    check("rst_rsp_trap",  72'(bus.rsp_trap),  72'(0));
    check("rst_mem_addr",  72'(bus.mem_addr),  72'(0));
    check("rst_mem_extra", 72'(bus.mem_extra), 72'(4'hF));
    check("rst_state",     72'(dbg_state),     72'(0));
    reset = 1'b0;

    // back-to-back directed vectors
    foreach (vecs[i]) send(vecs[i], 1'b1);

    // ROM error with the consumer stalling for 5 cycles
    begin
      int n = 0;
      while (bus.req_ready == 1'b0 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      bus.rsp_ready = 1'b0;
      send(v_err, 1'b1);
      n = 0;
      while (!bus.rsp_valid && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      if (!bus.rsp_valid) fail_now("stall_rsp_wait");
      repeat (5) @(posedge clk);
      #1;
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("stall_release_valid", 72'(bus.rsp_valid), 72'(0));
      check("stall_release_ready", 72'(bus.req_ready), 72'(1));
    end

    // reset while decoding aborts without a response
    begin
      int n = 0;
      send(v_rst, 1'b0);
      while (dbg_state != 3'd3 && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      if (dbg_state != 3'd3) fail_now("decode_wait");
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort_rsp_valid", 72'(bus.rsp_valid), 72'(0));
      check("abort_req_ready", 72'(bus.req_ready), 72'(1));
      check("abort_state",     72'(dbg_state),     72'(0));
      reset = 1'b0;
    end

    // recovery after the abort
    send(vecs[0], 1'b1);

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      if (exp_q.size() != 0) fail_now("drain");
    end
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
